pec_cnv_seq: RTL

- Initiator-side sequencer for one convolution row unit.
- Fetches activation and weight blocks from the PE buffers, issues them to the three chained MAC lanes, and waits for all three finish flags.
- Pulses accumulate once per output column and finish-row once per row.
- Sits between the PE buffer/controller and the convolution row datapath. It drives that datapath's start, accumulate and row-finish inputs.

---
 rtl/pec_cnv_seq_pkg.sv | 27 ++
 rtl/pec_cnv_seq_if.sv | 29 ++
 rtl/pec_fnh_join.sv | 25 ++
 rtl/pec_cnv_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pec_cnv_seq_pkg.sv
// Shared constants, sequencer state type and log2 helper for the
// convolution-row sequencer slice.
package pec_cnv_seq_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int BLOCK_DEPTH = 32;
  localparam int LENROW      = 16;
  localparam int NBLK_W      = 6;
  localparam int ADDR_W      = 10;

  // Ceiling log2; C_LOG_2(1) = 0, C_LOG_2(16) = 4.
  function automatic int C_LOG_2(input int unsigned value);
    int r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT_MAC,
    S_ACC,
    S_ROW_END
  } seq_state_e;

endpackage

// File: rtl/pec_cnv_seq_if.sv
// PE buffer fetch bus: activation and weight request/valid channels.
// master = sequencer side, slave = buffer side.
interface pec_cnv_seq_if #(
  parameter int DATA_WIDTH  = pec_cnv_seq_pkg::DATA_WIDTH,
  parameter int BLOCK_DEPTH = pec_cnv_seq_pkg::BLOCK_DEPTH,
  parameter int NBLK_W      = pec_cnv_seq_pkg::NBLK_W,
  parameter int ADDR_W      = pec_cnv_seq_pkg::ADDR_W
);
  logic                                act_req;
  logic [ADDR_W-1:0]                   act_addr;
  logic                                act_vld;
  logic [BLOCK_DEPTH-1:0]              act_flg_in;
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0]   act_dat_in;
  logic                                wei_req;
  logic [NBLK_W-1:0]                   wei_addr;
  logic                                wei_vld;
  logic [3*BLOCK_DEPTH-1:0]            wei_flg_in;
  logic [3*DATA_WIDTH*BLOCK_DEPTH-1:0] wei_dat_in;

  modport master (
    output act_req, act_addr, wei_req, wei_addr,
    input  act_vld, act_flg_in, act_dat_in, wei_vld, wei_flg_in, wei_dat_in
  );

  modport slave (
    input  act_req, act_addr, wei_req, wei_addr,
    output act_vld, act_flg_in, act_dat_in, wei_vld, wei_flg_in, wei_dat_in
  );
endinterface

// File: rtl/pec_fnh_join.sv
// Three-lane finish join: sticky finish bits, cleared by clr, collected
// only while en is high; all_done also counts pulses in the current cycle.
module pec_fnh_join (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic fnh0,
  input  logic fnh1,
  input  logic fnh2,
  output logic all_done
);
  logic [2:0] seen;
  logic [2:0] fnh_v;

  assign fnh_v    = {fnh2, fnh1, fnh0};
  assign all_done = en & (&(seen | fnh_v));

  // Sticky capture; clr wins so pulses in the clear cycle are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  seen <= '0;
    else if (clr) seen <= '0;
    else if (en)  seen <= seen | fnh_v;
  end
endmodule

// File: rtl/pec_cnv_seq.sv
// Convolution-row initiator sequencer: fetch act/weight blocks, start the
// three MAC lanes, join their finish pulses, pulse accumulate per column
// and finish-row per row.
// Optional zero-block skipping (and skip_cnt port) under PEC_SEQ_ZSKIP_EN.
module pec_cnv_seq #(
  parameter int DATA_WIDTH  = pec_cnv_seq_pkg::DATA_WIDTH,
  parameter int BLOCK_DEPTH = pec_cnv_seq_pkg::BLOCK_DEPTH,
  parameter int LENROW      = pec_cnv_seq_pkg::LENROW,
  parameter int NBLK_W      = pec_cnv_seq_pkg::NBLK_W,
  parameter int ADDR_W      = pec_cnv_seq_pkg::ADDR_W
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cfg_start,
  input  logic [NBLK_W-1:0]                            cfg_num_blk,
  input  logic [pec_cnv_seq_pkg::C_LOG_2(LENROW):0]    cfg_len_row,
  output logic                                         busy,
  output logic                                         done,
  pec_cnv_seq_if.master                                bus,
  output logic                                         mac_sta,
  input  logic                                         mac_fnh0,
  input  logic                                         mac_fnh1,
  input  logic                                         mac_fnh2,
  output logic [BLOCK_DEPTH-1:0]                       mac_flg_act,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]            mac_act,
  output logic [BLOCK_DEPTH-1:0]                       mac_flg_wei0,
  output logic [BLOCK_DEPTH-1:0]                       mac_flg_wei1,
  output logic [BLOCK_DEPTH-1:0]                       mac_flg_wei2,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]            mac_wei0,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]            mac_wei1,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]            mac_wei2,
  output logic                                         pls_acc,
  output logic                                         fnh_row
`ifdef PEC_SEQ_ZSKIP_EN
  ,
  output logic [15:0]                                  skip_cnt
`endif
);
  import pec_cnv_seq_pkg::*;

  localparam int LW = C_LOG_2(LENROW) + 1;
  localparam int DB = DATA_WIDTH * BLOCK_DEPTH;

  seq_state_e        state, state_nxt;
  logic [NBLK_W-1:0] num_blk, blk;
  logic [LW-1:0]     len_row, col;
  logic [ADDR_W-1:0] addr;
  logic              act_got, wei_got, act_take, wei_take;
  logic              fetched, skip, blk_adv, blk_last, col_last, all_done;

  assign bus.act_req  = (state == S_FETCH) && !act_got;
  assign bus.wei_req  = (state == S_FETCH) && !wei_got;
  assign bus.act_addr = addr;
  assign bus.wei_addr = blk;

  assign act_take = bus.act_req && bus.act_vld;
  assign wei_take = bus.wei_req && bus.wei_vld;
  assign fetched  = (state == S_FETCH) && (act_got || act_take) && (wei_got || wei_take);
  assign blk_last = (blk == num_blk - 1'b1);
  assign col_last = (col == len_row - 1'b1);

`ifdef PEC_SEQ_ZSKIP_EN
  logic [BLOCK_DEPTH-1:0]   act_flg_nxt;
  logic [3*BLOCK_DEPTH-1:0] wei_flg_nxt;
  // Skip decision looks at the flags as they will be after this cycle's capture.
  assign act_flg_nxt = act_take ? bus.act_flg_in : mac_flg_act;
  assign wei_flg_nxt = wei_take ? bus.wei_flg_in : {mac_flg_wei2, mac_flg_wei1, mac_flg_wei0};
  assign skip        = fetched && ((act_flg_nxt == '0) || (wei_flg_nxt == '0));
`else
  assign skip = 1'b0;
`endif

  assign blk_adv = skip || ((state == S_WAIT_MAC) && all_done);

  pec_fnh_join u_join (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == S_START),
    .en       (state == S_WAIT_MAC),
    .fnh0     (mac_fnh0),
    .fnh1     (mac_fnh1),
    .fnh2     (mac_fnh2),
    .all_done (all_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore pulse outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mac_sta   = 1'b0;
    pls_acc   = 1'b0;
    fnh_row   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:     if (cfg_start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (blk_adv)      state_nxt = blk_last ? S_ACC : S_FETCH;
        else if (fetched) state_nxt = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        mac_sta   = 1'b1;
        state_nxt = S_WAIT_MAC;
      end
      S_WAIT_MAC: begin
        busy = 1'b1;
        if (blk_adv) state_nxt = blk_last ? S_ACC : S_FETCH;
      end
      S_ACC: begin
        busy      = 1'b1;
        pls_acc   = 1'b1;
        state_nxt = col_last ? S_ROW_END : S_FETCH;
      end
      S_ROW_END: begin
        fnh_row   = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Config latch, column/block/address counters and fetch-capture flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_blk <= '0;
      len_row <= '0;
      col     <= '0;
      blk     <= '0;
      addr    <= '0;
      act_got <= 1'b0;
      wei_got <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cfg_start) begin
        num_blk <= (cfg_num_blk == '0) ? NBLK_W'(1) : cfg_num_blk;
        len_row <= (cfg_len_row == '0) ? LW'(1) : cfg_len_row;
        col     <= '0;
        blk     <= '0;
        addr    <= '0;
      end
      if (blk_adv && !blk_last) begin
        blk  <= blk + 1'b1;
        addr <= addr + 1'b1;
      end
      if (state == S_ACC) begin
        blk  <= '0;
        addr <= addr + 1'b1;
        if (!col_last) col <= col + 1'b1;
      end
      // A skipped block re-enters FETCH directly, so the flags clear on advance too.
      if ((state != S_FETCH) || blk_adv) begin
        act_got <= 1'b0;
        wei_got <= 1'b0;
      end else begin
        if (act_take) act_got <= 1'b1;
        if (wei_take) wei_got <= 1'b1;
      end
    end
  end

  // Lane data registers, loaded in the valid-sampling cycle and held until next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_flg_act  <= '0;
      mac_act      <= '0;
      mac_flg_wei0 <= '0;
      mac_flg_wei1 <= '0;
      mac_flg_wei2 <= '0;
      mac_wei0     <= '0;
      mac_wei1     <= '0;
      mac_wei2     <= '0;
    end else begin
      if (act_take) begin
        mac_flg_act <= bus.act_flg_in;
        mac_act     <= bus.act_dat_in;
      end
      if (wei_take) begin
        mac_flg_wei0 <= bus.wei_flg_in[0*BLOCK_DEPTH +: BLOCK_DEPTH];
        mac_flg_wei1 <= bus.wei_flg_in[1*BLOCK_DEPTH +: BLOCK_DEPTH];
        mac_flg_wei2 <= bus.wei_flg_in[2*BLOCK_DEPTH +: BLOCK_DEPTH];
        mac_wei0     <= bus.wei_dat_in[0*DB +: DB];
        mac_wei1     <= bus.wei_dat_in[1*DB +: DB];
        mac_wei2     <= bus.wei_dat_in[2*DB +: DB];
      end
    end
  end

`ifdef PEC_SEQ_ZSKIP_EN
  // Saturating count of skipped blocks, cleared on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            skip_cnt <= '0;
    else if ((state == S_IDLE) && cfg_start) skip_cnt <= '0;
    else if (skip && (skip_cnt != '1))     skip_cnt <= skip_cnt + 1'b1;
  end
`endif

endmodule
